reg_file_rename: RTL and testbench
==================================

// Module: reg_file_rename
// PURPOSE
//  Architectural register file with per-register rename tags. Dispatcher reads rs1/rs2 (value or producing ROB id)
//  and claims rd with the ROB id of the newly issued instruction. The ROB's in-order commit port writes values back.
//  A mispredict flush drops every in-flight tag. Sits between Dispatcher (issue side) and ROB (commit side).
// PARAMETERS
//  REG_NUM     32   architectural registers; x0 hardwired to zero
//  DATA_W      32   register value width
//  ROB_ID_W    5    tag width; ROB ids 0..15 valid
//  NON_DEP     16   tag value meaning "no pending producer"
// PORTS
//  clk               in   1         clock; all state updates on rising edge
//  rst               in   1         synchronous, active-high reset
//  rdy               in   1         global ready; low = hold all state (rst/flush still act)
//  mispredict        in   1         ROB flush; clears all tags this edge
//  enable_from_rob   in   1         commit write strobe (ROB enable_to_reg)
//  V_from_rob        in   DATA_W    committed value
//  Q_from_rob        in   ROB_ID_W  ROB id of committing instruction
//  rd_from_rob       in   5         destination register of committing instruction
//  enable_from_dsp   in   1         issue strobe: rename rd
//  rd_from_dsp       in   5         destination to rename
//  rob_id_from_dsp   in   ROB_ID_W  tag to install on rd
//  rs1_from_dsp      in   5         source 1 index
//  rs2_from_dsp      in   5         source 2 index
//  Vj_to_dsp         out  DATA_W    rs1 value (valid when Qj==NON_DEP)
//  Qj_to_dsp         out  ROB_ID_W  rs1 producer tag or NON_DEP
//  Vk_to_dsp         out  DATA_W    rs2 value
//  Qk_to_dsp         out  ROB_ID_W  rs2 producer tag or NON_DEP
// BEHAVIOUR
//  - State: val[REG_NUM] (DATA_W), tag[REG_NUM] (ROB_ID_W). Reset: all val=0, all tag=NON_DEP. Outputs are
//    combinational from state + bypass; after reset all reads return V=0, Q=NON_DEP.
//  - Edge priority: rst > mispredict > !rdy > normal. Flush (mispredict, rst=0): all tags := NON_DEP regardless of rdy;
//    a commit write in the same cycle still updates val (committed result is architectural); issue is ignored.
//  - Commit (enable_from_rob, rd!=0): val[rd] := V. tag[rd] := NON_DEP only if tag[rd]==Q_from_rob; otherwise a
//    younger producer owns rd and the tag is kept.
//  - Issue (enable_from_dsp, rd!=0): tag[rd] := rob_id_from_dsp. Issue and commit to the same rd in one cycle:
//    val written, new tag wins (issue beats the tag clear).
//  - x0: never written, never tagged; reads always V=0, Q=NON_DEP.
//  - Read bypass (same cycle): if enable_from_rob && rs==rd_from_rob && rs!=0 && tag[rs]==Q_from_rob, return
//    V=V_from_rob, Q=NON_DEP. Read does NOT see same-cycle issue (dispatcher resolves rs==rd of own instruction by
//    reading before rename). Bypass suppressed when mispredict=1 is irrelevant: flush edge clears tags anyway.
//  - Latency: write visible to read next cycle; commit visible same cycle via bypass.
//  - Tag wrap: ROB ids recycle; correctness relies on ROB never reissuing an id still held in tag[] (ROB full stall).
// STRUCTURE
//  - Shared define header: REG_NUMBER_WIDTH, DATA_WIDTH, ROB_ID_TYPE, NON_DEPENDENT (reuse existing macros).
//  - Single module; one internal function/always block for the read+bypass path, instantiated twice (rs1, rs2).
//  - No sub-module required; optional reg_read_port sub-module if the bypass logic is factored.
// TESTING
//  1 rst=1 one cycle -> every rs read gives V=0, Q=16.
//  2 issue rd=5 tag=3; next cycle read rs1=5 -> Q=3; commit rd=5 Q=3 V=0xAB -> same-cycle rs1=5 gives V=0xAB,Q=16;
//    next cycle tag=16, val=0xAB.
//  3 issue rd=7 tag=2, issue rd=7 tag=4, commit rd=7 Q=2 V=9 -> val[7]=9, tag[7]=4; read gives Q=4, no bypass.
//  4 same cycle: commit rd=8 Q=1 V=5 (tag[8]=1) and issue rd=8 tag=6 -> val[8]=5, tag[8]=6.
//  5 tags on x3,x9 pending, mispredict=1 with commit rd=3 Q=tag V=0x11 -> all tags 16, val[3]=0x11, issue ignored.
//  6 issue/commit to rd=0 with V=0xFF -> x0 reads V=0,Q=16; rdy=0 with issue rd=4 -> tag[4] unchanged.

Source files
------------

// File: rtl/reg_file_rename_pkg.sv
// Shared widths, tag encoding and value types for the renaming register file.
package reg_file_rename_pkg;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int ROB_ID_W  = 5;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ROB_ID_W-1:0]  rob_id_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // ROB ids 0..15 are real producers; 16 means the register holds its committed value.
    localparam rob_id_t NON_DEP = rob_id_t'(16);
endpackage

// File: rtl/reg_file_rename_read_port.sv
// One source-operand read port: architectural value/tag plus same-cycle commit bypass.
module reg_file_rename_read_port
    import reg_file_rename_pkg::*;
(
    input  reg_idx_t rs_i,
    input  data_t    val_i,
    input  rob_id_t  tag_i,
    input  logic     commit_en_i,
    input  reg_idx_t commit_rd_i,
    input  rob_id_t  commit_q_i,
    input  data_t    commit_v_i,
    output data_t    v_o,
    output rob_id_t  q_o
);
    logic bypass;

    // Only forward when the committing instruction is still the registered producer.
    assign bypass = commit_en_i && (rs_i == commit_rd_i) && (rs_i != '0) && (tag_i == commit_q_i);

    always_comb begin
        v_o = val_i;
        q_o = tag_i;
        if (rs_i == '0) begin
            v_o = '0;
            q_o = NON_DEP;
        end else if (bypass) begin
            v_o = commit_v_i;
            q_o = NON_DEP;
        end
    end
endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with rename tags: dispatcher reads/renames, ROB commits, mispredict flushes tags.
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     mispredict,
    input  logic     enable_from_rob,
    input  data_t    V_from_rob,
    input  rob_id_t  Q_from_rob,
    input  reg_idx_t rd_from_rob,
    input  logic     enable_from_dsp,
    input  reg_idx_t rd_from_dsp,
    input  rob_id_t  rob_id_from_dsp,
    input  reg_idx_t rs1_from_dsp,
    input  reg_idx_t rs2_from_dsp,
    output data_t    Vj_to_dsp,
    output rob_id_t  Qj_to_dsp,
    output data_t    Vk_to_dsp,
    output rob_id_t  Qk_to_dsp
);
    data_t   val_q [REG_NUM];
    data_t   val_d [REG_NUM];
    rob_id_t tag_q [REG_NUM];
    rob_id_t tag_d [REG_NUM];

    logic commit_ok;
    logic issue_ok;

    assign commit_ok = enable_from_rob && (rd_from_rob != '0);
    assign issue_ok  = enable_from_dsp && (rd_from_dsp != '0);

    always_comb begin
        // NOTE: next-state starts as a copy of current state so every path is assigned and no latch is inferred.
        val_d = val_q;
        tag_d = tag_q;
        if (mispredict) begin
            for (int i = 0; i < REG_NUM; i++) tag_d[i] = NON_DEP;
            if (commit_ok) val_d[rd_from_rob] = V_from_rob;
        end else if (rdy) begin
            if (commit_ok) begin
                val_d[rd_from_rob] = V_from_rob;
                if (tag_q[rd_from_rob] == Q_from_rob) tag_d[rd_from_rob] = NON_DEP;
            end
            // Issue comes after commit so a same-cycle rename of rd overrides the tag clear.
            if (issue_ok) tag_d[rd_from_dsp] = rob_id_from_dsp;
        end
    end

    // NOTE: the array is reset explicitly because readers rely on val=0/tag=NON_DEP right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= NON_DEP;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    reg_file_rename_read_port u_rs1 (
        .rs_i        (rs1_from_dsp),
        .val_i       (val_q[rs1_from_dsp]),
        .tag_i       (tag_q[rs1_from_dsp]),
        .commit_en_i (enable_from_rob),
        .commit_rd_i (rd_from_rob),
        .commit_q_i  (Q_from_rob),
        .commit_v_i  (V_from_rob),
        .v_o         (Vj_to_dsp),
        .q_o         (Qj_to_dsp)
    );

    reg_file_rename_read_port u_rs2 (
        .rs_i        (rs2_from_dsp),
        .val_i       (val_q[rs2_from_dsp]),
        .tag_i       (tag_q[rs2_from_dsp]),
        .commit_en_i (enable_from_rob),
        .commit_rd_i (rd_from_rob),
        .commit_q_i  (Q_from_rob),
        .commit_v_i  (V_from_rob),
        .v_o         (Vk_to_dsp),
        .q_o         (Qk_to_dsp)
    );
endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: reset, rename, commit bypass, tag ownership, flush, x0 and stall.
module tb_reg_file_rename;
    import reg_file_rename_pkg::*;

    logic     clk = 1'b0;
    logic     rst, rdy, mispredict;
    logic     enable_from_rob, enable_from_dsp;
    data_t    V_from_rob;
    rob_id_t  Q_from_rob, rob_id_from_dsp;
    reg_idx_t rd_from_rob, rd_from_dsp, rs1_from_dsp, rs2_from_dsp;
    data_t    Vj_to_dsp, Vk_to_dsp;
    rob_id_t  Qj_to_dsp, Qk_to_dsp;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .mispredict      (mispredict),
        .enable_from_rob (enable_from_rob),
        .V_from_rob      (V_from_rob),
        .Q_from_rob      (Q_from_rob),
        .rd_from_rob     (rd_from_rob),
        .enable_from_dsp (enable_from_dsp),
        .rd_from_dsp     (rd_from_dsp),
        .rob_id_from_dsp (rob_id_from_dsp),
        .rs1_from_dsp    (rs1_from_dsp),
        .rs2_from_dsp    (rs2_from_dsp),
        .Vj_to_dsp       (Vj_to_dsp),
        .Qj_to_dsp       (Qj_to_dsp),
        .Vk_to_dsp       (Vk_to_dsp),
        .Qk_to_dsp       (Qk_to_dsp)
    );

    task automatic idle();
        rst = 0; rdy = 1; mispredict = 0;
        enable_from_rob = 0; V_from_rob = '0; Q_from_rob = 5'd0; rd_from_rob = '0;
        enable_from_dsp = 0; rd_from_dsp = '0; rob_id_from_dsp = 5'd0;
    endtask

    // Let the edge happen, then settle 1 time unit past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input reg_idx_t rd, input rob_id_t id);
        enable_from_dsp = 1; rd_from_dsp = rd; rob_id_from_dsp = id;
        step();
        enable_from_dsp = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < REG_NUM; i++) begin
            rs1_from_dsp = reg_idx_t'(i);
            rs2_from_dsp = reg_idx_t'(REG_NUM - 1 - i);
            #1;
            tests_run++;
            if (Vj_to_dsp !== 32'd0 || Qj_to_dsp !== 5'd16 || Vk_to_dsp !== 32'd0 || Qk_to_dsp !== 5'd16) begin
                tests_failed++;
                $display("FAIL reset_read rs=%0d got Vj=%h Qj=%0d Vk=%h Qk=%0d want V=0 Q=16",
                         i, Vj_to_dsp, Qj_to_dsp, Vk_to_dsp, Qk_to_dsp);
            end
        end
    endtask

    task automatic test_issue_commit_bypass();
        issue(5'd5, 5'd3);
        rs1_from_dsp = 5'd5; #1;
        tests_run++;
        if (Qj_to_dsp !== 5'd3 || Vj_to_dsp !== 32'd0) begin
            tests_failed++; $display("FAIL renamed_read got V=%h Q=%0d want V=0 Q=3", Vj_to_dsp, Qj_to_dsp);
        end
        enable_from_rob = 1; rd_from_rob = 5'd5; Q_from_rob = 5'd3; V_from_rob = 32'hAB; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'hAB || Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL commit_bypass got V=%h Q=%0d want V=ab Q=16", Vj_to_dsp, Qj_to_dsp);
        end
        step();
        enable_from_rob = 0; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'hAB || Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL commit_written got V=%h Q=%0d want V=ab Q=16", Vj_to_dsp, Qj_to_dsp);
        end
    endtask

    task automatic test_younger_owner();
        issue(5'd7, 5'd2);
        issue(5'd7, 5'd4);
        enable_from_rob = 1; rd_from_rob = 5'd7; Q_from_rob = 5'd2; V_from_rob = 32'd9;
        rs1_from_dsp = 5'd7; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'd0 || Qj_to_dsp !== 5'd4) begin
            tests_failed++; $display("FAIL stale_commit_no_bypass got V=%h Q=%0d want V=0 Q=4", Vj_to_dsp, Qj_to_dsp);
        end
        step();
        enable_from_rob = 0; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'd9 || Qj_to_dsp !== 5'd4) begin
            tests_failed++; $display("FAIL stale_commit_keep_tag got V=%h Q=%0d want V=9 Q=4", Vj_to_dsp, Qj_to_dsp);
        end
    endtask

    task automatic test_same_cycle_issue_commit();
        issue(5'd8, 5'd1);
        enable_from_rob = 1; rd_from_rob = 5'd8; Q_from_rob = 5'd1; V_from_rob = 32'd5;
        enable_from_dsp = 1; rd_from_dsp = 5'd8; rob_id_from_dsp = 5'd6;
        rs2_from_dsp = 5'd8; #1;
        tests_run++;
        if (Vk_to_dsp !== 32'd5 || Qk_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL issue_commit_bypass got V=%h Q=%0d want V=5 Q=16", Vk_to_dsp, Qk_to_dsp);
        end
        step();
        enable_from_rob = 0; enable_from_dsp = 0; #1;
        tests_run++;
        if (Vk_to_dsp !== 32'd5 || Qk_to_dsp !== 5'd6) begin
            tests_failed++; $display("FAIL issue_beats_clear got V=%h Q=%0d want V=5 Q=6", Vk_to_dsp, Qk_to_dsp);
        end
    endtask

    task automatic test_mispredict();
        issue(5'd3, 5'd10);
        issue(5'd9, 5'd11);
        mispredict = 1;
        enable_from_rob = 1; rd_from_rob = 5'd3; Q_from_rob = 5'd10; V_from_rob = 32'h11;
        enable_from_dsp = 1; rd_from_dsp = 5'd12; rob_id_from_dsp = 5'd13;
        step();
        idle();
        rs1_from_dsp = 5'd3; rs2_from_dsp = 5'd9; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'h11 || Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL flush_commit_x3 got V=%h Q=%0d want V=11 Q=16", Vj_to_dsp, Qj_to_dsp);
        end
        tests_run++;
        if (Vk_to_dsp !== 32'd0 || Qk_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL flush_x9 got V=%h Q=%0d want V=0 Q=16", Vk_to_dsp, Qk_to_dsp);
        end
        rs1_from_dsp = 5'd12; rs2_from_dsp = 5'd7; #1;
        tests_run++;
        if (Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL flush_issue_ignored got Q=%0d want Q=16", Qj_to_dsp);
        end
        tests_run++;
        if (Vk_to_dsp !== 32'd9 || Qk_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL flush_x7 got V=%h Q=%0d want V=9 Q=16", Vk_to_dsp, Qk_to_dsp);
        end
    endtask

    task automatic test_x0_and_stall();
        enable_from_rob = 1; rd_from_rob = 5'd0; Q_from_rob = 5'd16; V_from_rob = 32'hFF;
        enable_from_dsp = 1; rd_from_dsp = 5'd0; rob_id_from_dsp = 5'd5;
        rs1_from_dsp = 5'd0; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'd0 || Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL x0_bypass got V=%h Q=%0d want V=0 Q=16", Vj_to_dsp, Qj_to_dsp);
        end
        step();
        idle(); #1;
        tests_run++;
        if (Vj_to_dsp !== 32'd0 || Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL x0_write got V=%h Q=%0d want V=0 Q=16", Vj_to_dsp, Qj_to_dsp);
        end
        rdy = 0;
        enable_from_dsp = 1; rd_from_dsp = 5'd4; rob_id_from_dsp = 5'd7;
        enable_from_rob = 1; rd_from_rob = 5'd4; Q_from_rob = 5'd3; V_from_rob = 32'h22;
        step();
        idle();
        rs1_from_dsp = 5'd4; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'd0 || Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL stall_hold got V=%h Q=%0d want V=0 Q=16", Vj_to_dsp, Qj_to_dsp);
        end
        issue(5'd4, 5'd7);
        rdy = 0; mispredict = 1;
        step();
        idle(); #1;
        tests_run++;
        if (Qj_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL stall_flush got Q=%0d want Q=16", Qj_to_dsp);
        end
    endtask

    task automatic test_back_to_back();
        issue(5'd10, 5'd0);
        issue(5'd11, 5'd1);
        enable_from_rob = 1; rd_from_rob = 5'd10; Q_from_rob = 5'd0; V_from_rob = 32'hDEAD_BEEF;
        rs1_from_dsp = 5'd10; rs2_from_dsp = 5'd11; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'hDEAD_BEEF || Qj_to_dsp !== 5'd16 || Qk_to_dsp !== 5'd1) begin
            tests_failed++; $display("FAIL b2b_commit0 got Vj=%h Qj=%0d Qk=%0d want Vj=deadbeef Qj=16 Qk=1",
                                     Vj_to_dsp, Qj_to_dsp, Qk_to_dsp);
        end
        step();
        rd_from_rob = 5'd11; Q_from_rob = 5'd1; V_from_rob = 32'h1234_5678; #1;
        tests_run++;
        if (Vj_to_dsp !== 32'hDEAD_BEEF || Qj_to_dsp !== 5'd16 || Vk_to_dsp !== 32'h1234_5678 || Qk_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL b2b_commit1 got Vj=%h Qj=%0d Vk=%h Qk=%0d want deadbeef/16 12345678/16",
                                     Vj_to_dsp, Qj_to_dsp, Vk_to_dsp, Qk_to_dsp);
        end
        step();
        idle(); #1;
        tests_run++;
        if (Vk_to_dsp !== 32'h1234_5678 || Qk_to_dsp !== 5'd16) begin
            tests_failed++; $display("FAIL b2b_final got V=%h Q=%0d want V=12345678 Q=16", Vk_to_dsp, Qk_to_dsp);
        end
    endtask

    initial begin
        idle();
        rs1_from_dsp = '0; rs2_from_dsp = '0;
        #2;
        test_reset();
        test_issue_commit_bypass();
        test_younger_owner();
        test_same_cycle_issue_commit();
        test_mispredict();
        test_x0_and_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
